// File: rtl/color_sequencer_if.sv
// Control and colour-output bundle for color_sequencer.
// master drives the control side; slave is the sequencer itself.
interface color_sequencer_if #(
    parameter int COLOR_W = 4,
    parameter int DIV_W   = 8
);
    logic               en;
    logic [1:0]         mode;
    logic [DIV_W-1:0]   div;
    logic               load;
    logic [COLOR_W-1:0] load_val;
    logic [COLOR_W-1:0] color;
    logic               step;
    logic               wrap;
    logic               dir;

    modport master (
        output en, mode, div, load, load_val,
        input  color, step, wrap, dir
    );

    modport slave (
        input  en, mode, div, load, load_val,
        output color, step, wrap, dir
    );
endinterface

// File: rtl/color_sequencer.sv
// Palette-index sequencer: up-wrap / down-wrap / ping-pong / hold over [COLOR_MIN..COLOR_MAX].
// Latency: a step event updates color, step and wrap on the same clock edge (all registered).
// Backpressure: none; en=0 freezes prescaler, colour and direction, load overrides everything.
module color_sequencer #(
    parameter int COLOR_W   = 4,
    parameter int COLOR_MIN = 2,
    parameter int COLOR_MAX = 5,
    parameter int DIV_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    color_sequencer_if.slave  sq
);

    localparam logic [COLOR_W-1:0] CMIN  = COLOR_W'(COLOR_MIN);
    localparam logic [COLOR_W-1:0] CMAX  = COLOR_W'(COLOR_MAX);
    localparam bit                 DEGEN = (COLOR_MIN == COLOR_MAX);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    // Direction is the only piece of sequencing state beyond the colour itself.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    logic [COLOR_W-1:0] color_q, color_d;
    logic [DIV_W-1:0]   cnt_q,   cnt_d;
    dir_e               dir_q,   dir_d;
    logic               step_q,  step_d;
    logic               wrap_q,  wrap_d;
    logic               fire;
    logic [COLOR_W-1:0] load_clamped;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_q <= CMIN;
            cnt_q   <= '0;
            dir_q   <= DIR_UP;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            color_q <= color_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        load_clamped = sq.load_val;
        if (sq.load_val < CMIN) begin
            load_clamped = CMIN;
        end else if (sq.load_val > CMAX) begin
            load_clamped = CMAX;
        end
    end

    always_comb begin
        color_d = color_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        fire    = 1'b0;

        if (sq.load) begin
            color_d = load_clamped;
            cnt_d   = '0;
        end else if (sq.en) begin
            // >= rather than == so a lowered div takes effect on the next enabled cycle.
            if (cnt_q >= sq.div) begin
                cnt_d = '0;
                fire  = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end

            if (fire) begin
                unique case (mode_e'(sq.mode))
                    MODE_UP: begin
                        step_d = 1'b1;
                        dir_d  = DIR_UP;
                        if (color_q == CMAX) begin
                            color_d = CMIN;
                            wrap_d  = 1'b1;
                        end else begin
                            color_d = color_q + COLOR_W'(1);
                        end
                    end
                    MODE_DOWN: begin
                        step_d = 1'b1;
                        dir_d  = DIR_DOWN;
                        if (color_q == CMIN) begin
                            color_d = CMAX;
                            wrap_d  = 1'b1;
                        end else begin
                            color_d = color_q - COLOR_W'(1);
                        end
                    end
                    MODE_PING: begin
                        step_d = 1'b1;
                        // Boundary checks come before +/-1; a single-entry range bounces in place.
                        if (dir_q == DIR_UP) begin
                            if (color_q == CMAX) begin
                                color_d = DEGEN ? color_q : color_q - COLOR_W'(1);
                                dir_d   = DIR_DOWN;
                                wrap_d  = 1'b1;
                            end else begin
                                color_d = color_q + COLOR_W'(1);
                            end
                        end else begin
                            if (color_q == CMIN) begin
                                color_d = DEGEN ? color_q : color_q + COLOR_W'(1);
                                dir_d   = DIR_UP;
                                wrap_d  = 1'b1;
                            end else begin
                                color_d = color_q - COLOR_W'(1);
                            end
                        end
                    end
                    MODE_HOLD: begin
                        color_d = color_q;
                    end
                    default: begin
                        color_d = color_q;
                    end
                endcase
            end
        end
    end

    assign sq.color = color_q;
    assign sq.step  = step_q;
    assign sq.wrap  = wrap_q;
    assign sq.dir   = dir_q;

endmodule

// File: doc/color_sequencer.md
Name: color_sequencer

Overview:
Parametrised colour-index generator that steps through a contiguous palette range [COLOR_MIN..COLOR_MAX] and drives a colour code to the display/LED path. It supports up-wrap, down-wrap, ping-pong and hold modes, a programmable step prescaler, enable gating, and a synchronous preload. It also flags sequence boundaries so downstream logic can count frames or cycles.

Parameters:
COLOR_W, 4, width of colour index output
COLOR_MIN, 2, lowest palette index in sequence
COLOR_MAX, 5, highest palette index in sequence; must satisfy COLOR_MIN <= COLOR_MAX <= 2^COLOR_W-1
DIV_W, 8, width of prescaler divide value

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
en  in  1  advance enable; when low, prescaler and colour freeze
mode  in  2  00 up-wrap, 01 down-wrap, 10 ping-pong, 11 hold
div  in  DIV_W  step every div+1 enabled cycles (0 = every cycle)
load  in  1  synchronous preload strobe
load_val  in  COLOR_W  preload colour value
color  out  COLOR_W  current colour index (registered)
step  out  1  one-cycle pulse, high in the cycle color takes a new stepped value
wrap  out  1  one-cycle pulse, high in the cycle color takes a boundary-crossing value
dir  out  1  current direction, 1 = up, 0 = down

Behaviour:
- Reset (async, rst=1): color=COLOR_MIN, prescaler cnt=0, dir=1, step=0, wrap=0. Release is sampled on the next clk edge.
- All outputs are registered. step and wrap default to 0 every cycle unless set as below.
- Priority per edge: load > en=0 > prescaler/step.
- Load: color <= load_val, clamped to COLOR_MIN if below, to COLOR_MAX if above. Also cnt <= 0; dir unchanged; step=0, wrap=0. Load acts even when en=0.
- en=0 and no load: cnt, color and dir hold; step=wrap=0.
- Prescaler: when en=1, a step event occurs if cnt >= div, and then cnt <= 0; otherwise cnt <= cnt+1. The >= comparison means lowering div mid-count fires on the next enabled cycle. Latency from step event to new color is the same edge.
- Step event by mode:
  - 00 up: color==COLOR_MAX ? COLOR_MIN with wrap=1 : color+1. dir <= 1.
  - 01 down: color==COLOR_MIN ? COLOR_MAX with wrap=1 : color-1. dir <= 0.
  - 10 ping-pong, dir=1: color==COLOR_MAX ? color-1, dir <= 0, wrap=1 : color+1.
  - 10 ping-pong, dir=0: color==COLOR_MIN ? color+1, dir <= 1, wrap=1 : color-1.
  - 11 hold: color and dir unchanged; step=0, wrap=0. The prescaler still runs.
  - step=1 on every step event in modes 00/01/10.
- Degenerate range COLOR_MIN==COLOR_MAX: color is constant. In modes 00/01/10, every step event gives step=1 and wrap=1. Ping-pong does not move, and dir toggles.
- Mode change is sampled at each step event; there is no reset of cnt or color. Entering ping-pong keeps the current dir.
- Out-of-range colour cannot occur except via load, which is clamped.
- Arithmetic uses COLOR_W bits. The wrap check precedes +/-1, so there is no overflow at 2^COLOR_W-1 or 0.
- Reset mid-count: cnt, color and dir return to reset values immediately; any pending step is lost.

Test Plan:
- Reset then en=1, mode=00, div=0 for 10 cycles -> color 2,3,4,5,2,3,4,5,2,3. wrap high exactly in the cycles showing 2 after 5; step high every cycle.
- mode=01, div=0 from color=2 -> 5,4,3,2,5. wrap high on 2->5; dir=0.
- mode=10, div=0 from reset -> 3,4,5,4,3,2,3. wrap on 5->4 and on 2->3; dir flips at those edges.
- mode=00, div=3, en toggled low for 2 cycles mid-count -> color advances once per 4 enabled cycles; frozen cycles add no count; step width is 1 cycle.
- load=1 with load_val=9 while en=1, then load_val=0 -> color=5 then 2 (clamped). cnt restarts, so the next step occurs div+1 enabled cycles later. Load wins over a coincident step.
- Async rst asserted between edges with color=4, div=5, cnt=3 -> color=2 and step=wrap=0 immediately. After release, first step occurs 6 enabled cycles later; mode=11 then holds color for 20 cycles with step=0.
